// File: rtl/status_array_pkg.sv
// Shared types and default sizing for the status array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package status_array_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  localparam int DEF_NUM_SETS   = 16;
  localparam int DEF_NUM_BLOCKS = 8;
  localparam int DEF_TAG_WIDTH  = 1;

endpackage

// File: rtl/status_init_fsm.sv
// Clear sweep controller: walks every row once after reset or flush, then enters service.
// Latency: NUM_SETS non-halted cycles from reset release or accepted flush to init_done.
// Backpressure: halt freezes state and counter; flush is ignored while sweeping.
module status_init_fsm
  import status_array_pkg::*;
#(
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  halt,
  input  logic                  flush,
  output logic                  init_done,
  output logic                  clr_vld,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_SETS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // State and sweep counter; reset wins over halt, halt freezes everything else.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else if (!halt) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep one row per cycle, restart the sweep on flush from service.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_vld = 1'b0;
    unique case (state_q)
      INIT: begin
        clr_vld = ~halt & ~srst;
        if (cnt_q == LAST_ROW) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (flush) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign init_done = (state_q == IDLE);
  assign clr_addr  = cnt_q;

endmodule

// File: rtl/status_array_v2.sv
// Flop-based per-block status bits with masked writes and a one-cycle tagged read.
// Latency: read data/tag one cycle after acceptance; same-row write is bypassed into the read.
// Backpressure: o_ready low during the clear sweep, on flush and while halted; halt freezes outputs.
module status_array_v2
  import status_array_pkg::*;
#(
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  i_halt,
  input  logic                  i_flush,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [ADDR_WIDTH-1:0] i_r_addr,
  input  logic                  i_r_valid,
  input  logic [ADDR_WIDTH-1:0] i_w_addr,
  input  logic [NUM_BLOCKS-1:0] i_w_data,
  input  logic [NUM_BLOCKS-1:0] i_w_wmask,
  input  logic                  i_w_valid,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [NUM_BLOCKS-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_ready,
  output logic                  o_init_done
);

  logic                  init_done;
  logic                  clr_vld;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [NUM_BLOCKS-1:0] wr_row;
  logic [NUM_BLOCKS-1:0] rd_row;
  logic [NUM_BLOCKS-1:0] rows_q [NUM_SETS];

  status_init_fsm #(
    .NUM_SETS   (NUM_SETS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_fsm (
    .clk       (clk),
    .srst      (srst),
    .halt      (i_halt),
    .flush     (i_flush),
    .init_done (init_done),
    .clr_vld   (clr_vld),
    .clr_addr  (clr_addr)
  );

  assign o_init_done = init_done;
  assign o_ready     = ~i_halt & init_done & ~i_flush;
  assign wr_acc      = i_w_valid & o_ready;
  assign rd_acc      = i_r_valid & o_ready;

  // Masked merge of the write into the addressed row; also the write-first read source.
  assign wr_row = (rows_q[i_w_addr] & ~i_w_wmask) | (i_w_data & i_w_wmask);
  assign rd_row = (wr_acc && (i_w_addr == i_r_addr)) ? wr_row : rows_q[i_r_addr];

  // Row storage: cleared one row at a time by the sweep, otherwise updated by accepted writes.
  always_ff @(posedge clk) begin
    if (clr_vld) begin
      rows_q[clr_addr] <= '0;
    end else if (wr_acc) begin
      rows_q[i_w_addr] <= wr_row;
    end
  end

  // Read return register: zero when no read was accepted, frozen while halted.
  always_ff @(posedge clk) begin
    if (srst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_tag   <= '0;
    end else if (!i_halt) begin
      o_valid <= rd_acc;
      o_data  <= rd_acc ? rd_row : '0;
      o_tag   <= rd_acc ? i_tag  : '0;
    end
  end

endmodule

// File: tb/tb_status_array_v2.sv
module tb_status_array_v2;

  localparam int NS = 16;
  localparam int NB = 8;
  localparam int TW = 1;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          srst;
  logic          i_halt;
  logic          i_flush;
  logic [TW-1:0] i_tag;
  logic [AW-1:0] i_r_addr;
  logic          i_r_valid;
  logic [AW-1:0] i_w_addr;
  logic [NB-1:0] i_w_data;
  logic [NB-1:0] i_w_wmask;
  logic          i_w_valid;
  logic [TW-1:0] o_tag;
  logic [NB-1:0] o_data;
  logic          o_valid;
  logic          o_ready;
  logic          o_init_done;

  status_array_v2 #(.NUM_SETS(NS), .NUM_BLOCKS(NB), .TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .srst       (srst),
    .i_halt     (i_halt),
    .i_flush    (i_flush),
    .i_tag      (i_tag),
    .i_r_addr   (i_r_addr),
    .i_r_valid  (i_r_valid),
    .i_w_addr   (i_w_addr),
    .i_w_data   (i_w_data),
    .i_w_wmask  (i_w_wmask),
    .i_w_valid  (i_w_valid),
    .o_tag      (o_tag),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_init_done(o_init_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: rows as a plain array, sweep position (-1 = in service).
  logic [NB-1:0] m_rows [NS];
  int            m_sweep = 0;
  logic          m_valid = 1'b0;
  logic [NB-1:0] m_data  = '0;
  logic [TW-1:0] m_tag   = '0;
  logic          m_rdy;
  logic          pre_ready;

  task automatic model_edge();
    m_rdy = !i_halt && (m_sweep < 0) && !i_flush;
    if (m_rdy && i_w_valid)
      for (int k = 0; k < NB; k++)
        if (i_w_wmask[k]) m_rows[i_w_addr][k] = i_w_data[k];
    if (srst) begin
      m_sweep = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_tag   = '0;
    end else if (!i_halt) begin
      if (m_sweep >= 0) begin
        m_rows[m_sweep] = '0;
        m_sweep = (m_sweep == NS - 1) ? -1 : m_sweep + 1;
      end else if (i_flush) begin
        m_sweep = 0;
      end
      m_valid = m_rdy && i_r_valid;
      m_data  = m_valid ? m_rows[i_r_addr] : '0;
      m_tag   = m_valid ? i_tag : '0;
    end
  endtask

  task automatic idle();
    srst = 0; i_halt = 0; i_flush = 0; i_tag = '0;
    i_r_addr = '0; i_r_valid = 0; i_w_addr = '0;
    i_w_data = '0; i_w_wmask = '0; i_w_valid = 0;
  endtask

  // One clock: sample o_ready with inputs settled, advance model, step past the edge.
  task automatic cyc();
    #1;
    pre_ready = o_ready;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!o_init_done && n < 100) begin
      cyc();
      n++;
    end
  endtask

  typedef struct {
    logic          halt, flush, rv;
    logic [AW-1:0] ra;
    logic [TW-1:0] tag;
    logic          wv;
    logic [AW-1:0] wa;
    logic [NB-1:0] wd, wm;
    logic          e_rdy, e_valid;
    logic [NB-1:0] e_data;
    logic [TW-1:0] e_tag;
  } vec_t;

  vec_t tbl [13];

  task automatic tv(input int i, input bit h, input bit f, input bit rv, input int ra, input int tg,
                    input bit wv, input int wa, input int wd, input int wm,
                    input bit er, input bit ev, input int ed, input int et);
    tbl[i].halt = h;  tbl[i].flush = f; tbl[i].rv = rv;
    tbl[i].ra = AW'(ra); tbl[i].tag = TW'(tg);
    tbl[i].wv = wv; tbl[i].wa = AW'(wa);
    tbl[i].wd = NB'(wd); tbl[i].wm = NB'(wm);
    tbl[i].e_rdy = er; tbl[i].e_valid = ev;
    tbl[i].e_data = NB'(ed); tbl[i].e_tag = TW'(et);
  endtask

  int n;
  string nm;

  initial begin
    //  i  h  f  rv ra tg wv wa wd    wm    rdy v  data  tag
    tv(0,  0, 0, 0, 0, 0, 1, 3, 'hFF, 'h0F, 1, 0, 'h00, 0);
    tv(1,  0, 0, 1, 3, 1, 0, 0, 0,    0,    1, 1, 'h0F, 1);
    tv(2,  0, 0, 0, 0, 0, 1, 5, 'h0C, 'hFF, 1, 0, 'h00, 0);
    tv(3,  0, 0, 1, 5, 0, 1, 5, 'hA0, 'hF0, 1, 1, 'hAC, 0);
    tv(4,  0, 0, 1, 5, 1, 1, 6, 'h55, 'hFF, 1, 1, 'hAC, 1);
    tv(5,  0, 0, 1, 6, 0, 0, 0, 0,    0,    1, 1, 'h55, 0);
    tv(6,  1, 0, 0, 0, 0, 0, 0, 0,    0,    0, 1, 'h55, 0);
    tv(7,  1, 0, 1, 3, 1, 0, 0, 0,    0,    0, 1, 'h55, 0);
    tv(8,  0, 0, 0, 0, 0, 0, 0, 0,    0,    1, 0, 'h00, 0);
    tv(9,  1, 0, 0, 0, 0, 1, 3, 'hFF, 'hFF, 0, 0, 'h00, 0);
    tv(10, 0, 0, 1, 3, 1, 0, 0, 0,    0,    1, 1, 'h0F, 1);
    tv(11, 1, 1, 0, 0, 0, 0, 0, 0,    0,    0, 1, 'h0F, 1);
    tv(12, 0, 0, 1, 6, 0, 0, 0, 0,    0,    1, 1, 'h55, 0);

    // Reset and initial sweep latency.
    idle();
    srst = 1;
    cyc();
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_tag", o_tag, 0);
    chk("rst_init_done", o_init_done, 0);
    srst = 0;
    wait_done(n);
    chk("init_latency", n, NS);

    // Table-driven function vectors.
    for (int i = 0; i < 13; i++) begin
      idle();
      i_halt = tbl[i].halt; i_flush = tbl[i].flush;
      i_r_valid = tbl[i].rv; i_r_addr = tbl[i].ra; i_tag = tbl[i].tag;
      i_w_valid = tbl[i].wv; i_w_addr = tbl[i].wa;
      i_w_data = tbl[i].wd; i_w_wmask = tbl[i].wm;
      cyc();
      nm = $sformatf("vec%0d", i);
      chk({nm, "_ready"}, pre_ready, tbl[i].e_rdy);
      chk({nm, "_valid"}, o_valid, tbl[i].e_valid);
      chk({nm, "_data"}, o_data, tbl[i].e_data);
      chk({nm, "_tag"}, o_tag, tbl[i].e_tag);
      chk({nm, "_done"}, o_init_done, 1);
    end

    // Flush: populate, pulse flush, count not-ready cycles (second flush mid-sweep ignored).
    for (int i = 0; i < NS; i++) begin
      idle();
      i_w_valid = 1; i_w_addr = AW'(i); i_w_data = NB'(i * 17 + 1); i_w_wmask = '1;
      cyc();
    end
    n = 0;
    while (n < 100) begin
      idle();
      i_flush = (n == 0 || n == 5);
      cyc();
      if (pre_ready) break;
      n++;
    end
    chk("flush_not_ready_cycles", n, NS + 1);
    for (int i = 0; i < NS; i++) begin
      idle();
      i_r_valid = 1; i_r_addr = AW'(i);
      cyc();
      chk($sformatf("flush_row%0d_valid", i), o_valid, 1);
      chk($sformatf("flush_row%0d_data", i), o_data, 0);
    end

    // Halt for 3 cycles once the sweep counter reaches 7.
    idle();
    srst = 1;
    cyc();
    srst = 0;
    n = 0;
    while (!o_init_done && n < 100) begin
      i_halt = (n >= 7 && n < 10);
      cyc();
      n++;
    end
    i_halt = 0;
    chk("halt_init_latency", n, NS + 3);

    // Reset during a read: pending data dropped, sweep restarts and clears the row.
    idle();
    i_w_valid = 1; i_w_addr = 4; i_w_data = 8'h3C; i_w_wmask = '1;
    cyc();
    idle();
    i_r_valid = 1; i_r_addr = 4; i_tag = 1;
    cyc();
    chk("pre_srst_read", o_data, 8'h3C);
    srst = 1;
    cyc();
    chk("srst_read_valid", o_valid, 0);
    chk("srst_read_tag", o_tag, 0);
    chk("srst_read_done", o_init_done, 0);
    idle();
    wait_done(n);
    chk("srst_restart_latency", n, NS);
    i_r_valid = 1; i_r_addr = 4;
    cyc();
    chk("srst_row4_cleared", o_data, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      srst      = ($urandom % 200) == 0;
      i_halt    = ($urandom % 8) == 0;
      i_flush   = ($urandom % 40) == 0;
      i_r_valid = $urandom % 2;
      i_w_valid = $urandom % 2;
      i_r_addr  = AW'($urandom);
      i_w_addr  = ($urandom % 3 == 0) ? i_r_addr : AW'($urandom);
      i_w_data  = NB'($urandom);
      i_w_wmask = NB'($urandom);
      i_tag     = TW'($urandom);
      cyc();
      chk("rand_ready", pre_ready, m_rdy);
      chk("rand_valid", o_valid, m_valid);
      chk("rand_data", o_data, m_data);
      chk("rand_tag", o_tag, m_tag);
      chk("rand_done", o_init_done, m_sweep < 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
